exu_ctrl: RTL
=============

EXU_CTRL -- requirements
Module: ysyx_22050710_exu_ctrl

Interface
REQ-001 SHALL have parameter WORD_WD, default 64, result width.
REQ-002 SHALL have parameter MDU_TIMEOUT, default 70, max MDU wait cycles before abort (1..127).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state is clocked on its rising edge.
REQ-004 SHALL have ports:
 i_clk  in  1  clock
 i_rst  in  1  async reset, active-high
 i_id_valid  in  1  ID stage offers an instruction
 o_id_ready  out  1  controller accepts an instruction
 i_is_mdu  in  1  instruction needs the multi-cycle mul/div unit
 i_ebreak_sel  in  1  instruction is ebreak
 i_invalid_inst_sel  in  1  instruction is invalid
 i_alu_result  in  WORD_WD  single-cycle ALU result
 o_mdu_start  out  1  one-cycle MDU start pulse
 i_mdu_done  in  1  MDU result valid
 i_mdu_result  in  WORD_WD  MDU result
 i_flush  in  1  discard in-flight instruction
 o_ex_valid  out  1  result offered to LS stage
 i_ls_ready  in  1  LS stage accepts result
 o_ex_result  out  WORD_WD  registered result
 o_trap_end  out  1  one-cycle pulse, simulation end (ebreak)
 o_trap_abort  out  1  one-cycle pulse, simulation abort
 o_busy  out  1  state is not IDLE

Function
REQ-005 SHALL implement states IDLE, MDU_WAIT, HOLD, HALT.
REQ-006 o_id_ready SHALL be 1 only in IDLE with i_flush=0; accept = i_id_valid & o_id_ready.
REQ-007 On accept, decode priority: invalid > ebreak > mdu > alu.
REQ-008 Accept of invalid: HALT next cycle, o_trap_abort=1 for that one cycle.
REQ-009 Accept of ebreak: HALT next cycle, o_trap_end=1 for that one cycle.
REQ-010 Accept of mdu op: MDU_WAIT next cycle; o_mdu_start=1 only in the first MDU_WAIT cycle; wait counter cleared to 0.
REQ-011 Accept of alu op: capture i_alu_result into o_ex_result; HOLD next cycle (1-cycle latency).
REQ-012 MDU_WAIT: counter increments each cycle, saturating at 127; i_mdu_done=1 captures i_mdu_result and moves to HOLD next cycle.
REQ-013 MDU_WAIT: counter == MDU_TIMEOUT with i_mdu_done=0 -> HALT next cycle, o_trap_abort pulse; done and timeout in the same cycle -> done wins.
REQ-014 i_mdu_done outside MDU_WAIT SHALL be ignored.
REQ-015 o_ex_valid SHALL be 1 exactly in HOLD; o_ex_result stable while in HOLD.
REQ-016 HOLD with i_ls_ready=1 -> IDLE next cycle; otherwise stay in HOLD.
REQ-017 i_flush=1 in MDU_WAIT or HOLD -> IDLE next cycle, result discarded, no trap; flush beats i_mdu_done and i_ls_ready in the same cycle.
REQ-018 i_flush in IDLE blocks accept; i_flush in HALT has no effect.
REQ-019 HALT SHALL be absorbing until reset; o_id_ready=0, o_ex_valid=0, no further pulses.
REQ-020 o_trap_end and o_trap_abort SHALL never both be 1; each pulses at most once per reset.

Reset
REQ-021 Reset asserted SHALL immediately force IDLE, counter 0, o_ex_result 0, o_ex_valid 0, o_mdu_start 0, o_trap_end 0, o_trap_abort 0, o_busy 0.
REQ-022 Reset mid-operation (MDU_WAIT, HOLD, HALT) SHALL drop the instruction with no pulse; o_id_ready=1 in the first cycle after release.

Verification
REQ-023 ALU op: accept with i_alu_result=0x1234, i_ls_ready=1 -> next cycle o_ex_valid=1, o_ex_result=0x1234; IDLE the cycle after.
REQ-024 MDU op: accept, i_mdu_done with 0xDEAD 5 cycles later -> o_mdu_start pulses once; o_ex_valid=1 next cycle with 0xDEAD.
REQ-025 Timeout: MDU op, i_mdu_done held 0 -> o_trap_abort pulses when counter reaches 70; HALT; later i_id_valid not accepted.
REQ-026 Back-pressure then flush: ALU op, i_ls_ready=0 for 3 cycles then i_flush=1 -> o_ex_valid drops next cycle; o_id_ready returns 1.
REQ-027 Priority: one instruction with i_ebreak_sel=1 and i_invalid_inst_sel=1 -> only o_trap_abort pulses; HALT.
REQ-028 Async reset during MDU_WAIT, then i_mdu_done=1 after release -> all outputs 0, done ignored, state IDLE.

Source files
------------

// File: rtl/exu_ctrl.sv
// Execute-stage controller: sequences single-cycle ALU ops, multi-cycle MDU ops and traps.
// Latency: ALU result valid 1 cycle after accept; MDU result valid 1 cycle after i_mdu_done.
// Backpressure: result held in HOLD until i_ls_ready; no new accept outside IDLE or while flushing.
module exu_ctrl #(
  parameter int WORD_WD     = 64,
  parameter int MDU_TIMEOUT = 70   // legal range 1..127, compared against a 7-bit counter
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_id_valid,
  output logic               o_id_ready,
  input  logic               i_is_mdu,
  input  logic               i_ebreak_sel,
  input  logic               i_invalid_inst_sel,
  input  logic [WORD_WD-1:0] i_alu_result,
  output logic               o_mdu_start,
  input  logic               i_mdu_done,
  input  logic [WORD_WD-1:0] i_mdu_result,
  input  logic               i_flush,
  output logic               o_ex_valid,
  input  logic               i_ls_ready,
  output logic [WORD_WD-1:0] o_ex_result,
  output logic               o_trap_end,
  output logic               o_trap_abort,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HOLD     = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [6:0] LP_TIMEOUT = 7'(MDU_TIMEOUT);
  localparam logic [6:0] LP_CNT_MAX = 7'd127;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_cnt;
  logic [6:0]         w_cnt_nxt;
  logic [WORD_WD-1:0] r_result;
  logic [WORD_WD-1:0] w_result_nxt;
  logic               r_mdu_start;
  logic               w_mdu_start_nxt;
  logic               r_trap_end;
  logic               w_trap_end_nxt;
  logic               r_trap_abort;
  logic               w_trap_abort_nxt;

  logic               w_id_ready;
  logic               w_accept;

  // Handshake with ID: only an idle, non-flushing controller takes a new instruction.
  assign w_id_ready = (r_state == ST_IDLE) && !i_flush;
  assign w_accept   = i_id_valid && w_id_ready;

  // Next-state, counter, result capture and registered pulse requests.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_result_nxt     = r_result;
    w_mdu_start_nxt  = 1'b0;
    w_trap_end_nxt   = 1'b0;
    w_trap_abort_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // Decode priority: invalid > ebreak > mdu > alu.
          if (i_invalid_inst_sel) begin
            w_state_nxt      = ST_HALT;
            w_trap_abort_nxt = 1'b1;
          end else if (i_ebreak_sel) begin
            w_state_nxt    = ST_HALT;
            w_trap_end_nxt = 1'b1;
          end else if (i_is_mdu) begin
            w_state_nxt     = ST_MDU_WAIT;
            w_cnt_nxt       = 7'd0;
            w_mdu_start_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_HOLD;
            w_result_nxt = i_alu_result;
          end
        end
      end

      ST_MDU_WAIT: begin
        // Counter runs every wait cycle and sticks at its maximum.
        if (r_cnt != LP_CNT_MAX) begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
        // Flush beats done, and done beats a timeout landing in the same cycle.
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 7'd0;
        end else if (i_mdu_done) begin
          w_state_nxt  = ST_HOLD;
          w_result_nxt = i_mdu_result;
        end else if (r_cnt == LP_TIMEOUT) begin
          w_state_nxt      = ST_HALT;
          w_trap_abort_nxt = 1'b1;
        end
      end

      ST_HOLD: begin
        // Flush discards the held result; otherwise wait for LS to take it.
        if (i_flush || i_ls_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_HALT: begin
        // Absorbing until reset: nothing is accepted and no pulse is repeated.
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction silently.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 7'd0;
      r_result     <= '0;
      r_mdu_start  <= 1'b0;
      r_trap_end   <= 1'b0;
      r_trap_abort <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_result     <= w_result_nxt;
      r_mdu_start  <= w_mdu_start_nxt;
      r_trap_end   <= w_trap_end_nxt;
      r_trap_abort <= w_trap_abort_nxt;
    end
  end

  assign o_id_ready   = w_id_ready;
  assign o_mdu_start  = r_mdu_start;
  assign o_ex_valid   = (r_state == ST_HOLD);
  assign o_ex_result  = r_result;
  assign o_trap_end   = r_trap_end;
  assign o_trap_abort = r_trap_abort;
  assign o_busy       = (r_state != ST_IDLE);

  // The two trap pulses are mutually exclusive.
  a_trap_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_trap_end && o_trap_abort));

  // An MDU start pulse is only ever seen in the wait state.
  a_start_in_wait: assert property (@(posedge i_clk) disable iff (i_rst)
    o_mdu_start |-> (r_state == ST_MDU_WAIT));

  // A trap pulse is only ever seen after entering HALT.
  a_trap_in_halt: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_trap_end || o_trap_abort) |-> (r_state == ST_HALT));

endmodule
